// File: rtl/seg7_pkg.sv
// Shared constants, state encoding and segment lookup for the multi-digit
// 7-segment display driver (segment bit order g..a, active-low).
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    // Codes 10-15 are not BCD; show a dash rather than garbage.
    function automatic logic [6:0] seg_code(input logic [3:0] digit);
        logic [6:0] code_v;
        case (digit)
            4'd0:    code_v = 7'b1000000;
            4'd1:    code_v = 7'b1111001;
            4'd2:    code_v = 7'b0100100;
            4'd3:    code_v = 7'b0110000;
            4'd4:    code_v = 7'b0011001;
            4'd5:    code_v = 7'b0010010;
            4'd6:    code_v = 7'b0000010;
            4'd7:    code_v = 7'b1111000;
            4'd8:    code_v = 7'b0000000;
            4'd9:    code_v = 7'b0010000;
            default: code_v = SEG_DASH;
        endcase
        return code_v;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Single-digit decoder: 4-bit BCD plus blank request to an active-low
// 7-segment code.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    // Blank overrides the digit value.
    always_comb begin
        seg = SEG_BLANK;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            seg = seg_code(bcd);
        end
    end

endmodule

// File: rtl/seg7_multi_display.sv
// Multi-digit 7-segment driver: sequential double-dabble binary-to-BCD
// conversion behind a valid/ready handshake, with blanking, overflow and blink.
module seg7_multi_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int BIN_WIDTH  = 20,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [BIN_WIDTH-1:0]         in_value,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         lz_blank,
    input  logic                         blink_en,
    output logic                         done,
    output logic                         overflow,
    output logic [NUM_DIGITS-1:0][6:0]   hex
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_ONE  = BLK_W'(1);

    state_t                       state_r;
    state_t                       state_s;
    logic [BIN_WIDTH-1:0]         bin_r;
    logic [BCD_W-1:0]             bcd_r;
    logic [BCD_W-1:0]             adj_s;
    logic                         ovf_scr_r;
    logic                         lz_r;
    logic [CNT_W-1:0]             cnt_r;
    logic [NUM_DIGITS-1:0][6:0]   hex_r;
    logic [NUM_DIGITS-1:0][6:0]   code_s;
    logic [6:0]                   dec_s [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]        blank_s;
    logic                         ovf_r;
    logic                         done_r;
    logic [BLK_W-1:0]             blk_cnt_r;
    logic                         phase_r;

    assign in_ready = (state_r == IDLE);
    assign done     = done_r;
    assign overflow = ovf_r;

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = LOAD;
                end else begin
                    state_s = SHIFT;
                end
            end
            LOAD:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Add-3 correction on every BCD digit of 5 or more before the shift.
    always_comb begin
        adj_s = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_r[4*i +: 4] >= 4'd5) begin
                adj_s[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
            end else begin
                adj_s[4*i +: 4] = bcd_r[4*i +: 4];
            end
        end
    end

    // Double-dabble datapath; a 1 leaving the top digit means overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_r     <= '0;
            bcd_r     <= '0;
            ovf_scr_r <= 1'b0;
            lz_r      <= 1'b0;
            cnt_r     <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        bin_r     <= in_value;
                        bcd_r     <= '0;
                        ovf_scr_r <= 1'b0;
                        lz_r      <= lz_blank;
                        cnt_r     <= '0;
                    end
                end
                SHIFT: begin
                    bcd_r     <= {adj_s[BCD_W-2:0], bin_r[BIN_WIDTH-1]};
                    bin_r     <= bin_r << 1;
                    ovf_scr_r <= ovf_scr_r | adj_s[BCD_W-1];
                    cnt_r     <= cnt_r + CNT_ONE;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Leading-zero scan from the most significant digit; digit 0 always shows.
    always_comb begin
        logic nz_v;
        nz_v    = 1'b0;
        blank_s = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nz_v       = nz_v | (bcd_r[4*i +: 4] != 4'd0);
            blank_s[i] = lz_r & ~nz_v & (i != 0);
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        bcd_to_seg7 u_dec (
            .bcd   (bcd_r[4*g +: 4]),
            .blank (blank_s[g]),
            .seg   (dec_s[g])
        );
    end

    // Overflow replaces every digit with a dash.
    always_comb begin
        code_s = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (ovf_scr_r) begin
                code_s[i] = SEG_DASH;
            end else begin
                code_s[i] = dec_s[i];
            end
        end
    end

    // Display registers update only at the end of a conversion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hex_r  <= {NUM_DIGITS{SEG_BLANK}};
            ovf_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= (state_r == LOAD);
            if (state_r == LOAD) begin
                hex_r <= code_s;
                ovf_r <= ovf_scr_r;
            end
        end
    end

    // Free-running blink divider; phase flips on every wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blk_cnt_r <= '0;
            phase_r   <= 1'b0;
        end else if (blk_cnt_r == BLK_LAST) begin
            blk_cnt_r <= '0;
            phase_r   <= ~phase_r;
        end else begin
            blk_cnt_r <= blk_cnt_r + BLK_ONE;
        end
    end

    // Blink mask is applied after the registers so stored digits survive.
    always_comb begin
        hex = hex_r;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (blink_en && phase_r) begin
                hex[i] = SEG_BLANK;
            end else begin
                hex[i] = hex_r[i];
            end
        end
    end

endmodule

// File: tb/tb_seg7_multi_display.sv
// Scoreboard bench for seg7_multi_display: driver queues decimal-model
// expectations, a negedge monitor checks them whenever done pulses.
module tb_seg7_multi_display;

    localparam int ND = 6;
    localparam int BW = 20;
    localparam int BD = 4;
    localparam logic [41:0] ALL_BLANK = {6{7'b1111111}};

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [BW-1:0]     in_value = '0;
    logic              in_valid = 1'b0;
    logic              lz_blank = 1'b0;
    logic              blink_en = 1'b0;
    logic              in_ready;
    logic              done;
    logic              overflow;
    logic [ND-1:0][6:0] hex;

    seg7_multi_display #(.NUM_DIGITS(ND), .BIN_WIDTH(BW), .BLINK_DIV(BD)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_value (in_value),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .lz_blank (lz_blank),
        .blink_en (blink_en),
        .done     (done),
        .overflow (overflow),
        .hex      (hex)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [41:0] hex;
        logic        ovf;
        logic [31:0] cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [41:0] shown = ALL_BLANK;
    int unsigned cyc = 0;
    int unsigned nedge = 0;
    int          total = 0;
    int          bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Edges elapsed since reset release, used to derive the blink phase.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) nedge <= 0;
        else          nedge <= nedge + 1;
    end

    function automatic logic [6:0] seg_of(int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Decimal reference: digit i is (v / 10^i) mod 10, dashes above 999999.
    function automatic logic [41:0] model(int unsigned v, bit lz);
        logic [41:0]     r;
        longint unsigned p;
        r = '0;
        p = 1;
        for (int i = 0; i < ND; i++) begin
            if (v > 999999)               r[7*i +: 7] = 7'b0111111;
            else if (lz && i > 0 && v < p) r[7*i +: 7] = 7'b1111111;
            else                           r[7*i +: 7] = seg_of(int'((v / p) % 10));
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [41:0] visible(logic [41:0] s);
        if (blink_en && ((nedge / BD) % 2 == 1)) return ALL_BLANK;
        return s;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset_n && done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done: got done=1 expected no pulse");
            end else begin
                mon_e = sb.pop_front();
                chk("hex", 64'(hex), 64'(visible(mon_e.hex)));
                chk("overflow", 64'(overflow), 64'(mon_e.ovf));
                chk("latency", 64'(cyc), 64'(mon_e.cyc));
                chk("ready_at_done", 64'(in_ready), 64'd1);
                shown = mon_e.hex;
            end
        end
    end

    task automatic send(input logic [BW-1:0] v, input bit lz);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        @(negedge clk);
        in_value = v;
        lz_blank = lz;
        in_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            if (in_ready) begin
                e.hex = model(int'(v), lz);
                e.ovf = (int'(v) > 999999);
                e.cyc = cyc + 1 + BW + 1;
                sb.push_back(e);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got in_ready=0 for 100 cycles expected 1");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            chk("busy_after_accept", 64'(in_ready), 64'd0);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && sb.size() != 0; n++) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_hex"}, 64'(hex), 64'(ALL_BLANK));
        chk({tag, "_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_ovf"}, 64'(overflow), 64'd0);
    endtask

    initial begin
        logic [BW-1:0] v;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        reset_n = 1'b1;

        send(20'd1234, 1'b0);
        send(20'd1234, 1'b1);
        send(20'd999999, 1'b0);
        send(20'd1000000, 1'b0);
        send(20'd0, 1'b1);
        send(20'd1048575, 1'b1);
        idle();
        drain();

        send(20'd42, 1'b0);
        send(20'd77, 1'b0);
        idle();
        drain();
        chk("hold_77", 64'(hex), 64'(model(77, 1'b0)));

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 3))
                0:       v = 20'($urandom_range(0, 999));
                1:       v = 20'($urandom_range(0, 999999));
                2:       v = 20'($urandom_range(999990, 1048575));
                default: v = 20'($urandom_range(0, 1048575));
            endcase
            send(v, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                idle();
                repeat ($urandom_range(0, 5)) @(negedge clk);
            end
        end
        idle();
        drain();

        blink_en = 1'b1;
        for (int t = 0; t < 16; t++) begin
            @(negedge clk);
            chk("blink_on", 64'(hex), 64'(visible(shown)));
        end
        blink_en = 1'b0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            chk("blink_off", 64'(hex), 64'(shown));
        end

        send(20'd123456, 1'b1);
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        in_valid = 1'b0;
        #1;
        sb.delete();
        shown = ALL_BLANK;
        chk_reset_state("midreset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("post_abort_hex", 64'(hex), 64'(ALL_BLANK));
        send(20'd654321, 1'b0);
        idle();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/seg7_multi_display.md
# seg7_multi_display

Parametrised multi-digit 7-segment display driver that accepts an unsigned binary value through a valid/ready handshake. It converts the value to BCD with a sequential shift-and-add-3 (double-dabble) engine, one bit per cycle. It drives NUM_DIGITS active-low HEX outputs with optional leading-zero blanking, overflow indication and display blinking. It sits between datapath counters/results and the board HEX displays, replacing per-digit single-decoder instantiation.

## Interface
- NUM_DIGITS, 6: number of HEX digits driven; legal range 1–8.
- BIN_WIDTH, 20: width of the binary input; legal range 1–27.
- BLINK_DIV, 25_000_000: cycles per blink half-period; legal range ≥ 1.
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_value  in  BIN_WIDTH  unsigned binary value to display.
- in_valid  in  1  in_value is presented.
- in_ready  out  1  engine idle; a transfer occurs when in_valid && in_ready at a rising edge.
- lz_blank  in  1  leading-zero blanking enable, sampled with in_value.
- blink_en  in  1  blink enable, used live (not sampled).
- done  out  1  one-cycle pulse in the cycle the HEX registers update.
- overflow  out  1  the latched value exceeds 10^NUM_DIGITS − 1; held until the next update.
- hex  out  NUM_DIGITS×7  packed array; hex[i] is digit i (0 = least significant), bit order g..a, active-low.

## Operation
- Segment codes (g..a, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, BLANK=1111111, DASH=0111111.
- FSM states:
  - IDLE: in_ready=1. On transfer, latch in_value into the shift register, clear the BCD register (NUM_DIGITS×4 bits), clear the overflow scratch bit, latch lz_blank, clear the bit counter, and go to SHIFT.
  - SHIFT: each cycle, add 3 to every BCD digit ≥ 5, then shift {BCD, bin} left by one. If the bit shifted out of the top BCD digit is 1, set the overflow scratch bit. After BIN_WIDTH shifts, go to LOAD.
  - LOAD: register the digit codes into hex, copy the scratch bit to overflow, pulse done, and go to IDLE.
- Display mapping at LOAD:
  - If overflow, every digit shows DASH.
  - Otherwise digit i shows its BCD code.
  - If lz_blank=1, every digit i>0 above the most significant nonzero digit shows BLANK. Digit 0 is never blanked, so value 0 shows "0".
- hex holds its value between conversions.
- Blink:
  - A free-running counter wraps at BLINK_DIV−1 and toggles a phase bit on wrap.
  - The counter and phase run regardless of blink_en.
  - When blink_en=1 and phase=1, every hex output is forced to BLANK combinationally from the registers. The stored digits are unaffected.
- in_valid while in_ready=0 is ignored; no queuing.
- Values with BIN_WIDTH < 4·NUM_DIGITS that cannot overflow never set overflow.

## Timing
- Reset (asynchronous assert, synchronous-clean deassert):
  - FSM=IDLE, in_ready=1, done=0, overflow=0.
  - All hex digits BLANK; blink counter=0, phase=0.
- Transfer at edge k: in_ready=0 from edge k to edge k+BIN_WIDTH+1.
- done=1 and new hex/overflow visible in cycle k+BIN_WIDTH+1. in_ready=1 again in that same cycle.
- Back-to-back: a new transfer is accepted at edge k+BIN_WIDTH+2 at the earliest.
- Throughput is one conversion per BIN_WIDTH+2 cycles.
- Reset asserted mid-conversion aborts immediately to reset values. No done pulse is produced.
- blink_en toggling takes effect in the same cycle (combinational mask).

## Structure
- Package seg7_pkg holds:
  - SEG_BLANK and SEG_DASH constants.
  - The 10-entry digit code function/array.
  - The state enum (IDLE, SHIFT, LOAD).
- Sub-module bcd_to_seg7: 4-bit BCD plus blank input to 7-bit code. Out-of-range codes 10–15 map to DASH, never X. It is instantiated NUM_DIGITS times in a generate loop.
- The top contains the FSM, the double-dabble datapath, the leading-zero scan and the blink counter.

## Test plan
All scenarios use NUM_DIGITS=6 and BIN_WIDTH=20 unless stated.
- Reset: assert reset_n=0 mid-run → all six hex=1111111, in_ready=1, done=0, overflow=0.
- 1234 with lz_blank=0, accepted at edge k → done at k+21; hex[5..0]=1000000,1000000,1111001,0100100,0110000,0011001. Repeat with lz_blank=1 → hex5 and hex4 are 1111111.
- Boundary values:
  - 999999 → all digits 0010000, overflow=0.
  - 1000000 → all digits 0111111, overflow=1.
  - 0 with lz_blank=1 → hex0=1000000, the rest 1111111.
- Busy handshake: hold in_valid=1 with 42 then 77 → 42 is accepted; 77 is accepted only when in_ready returns; displays 42, then 77 after a second done.
- Blink with BLINK_DIV=4, blink_en=1 → hex alternates stored/BLANK every 4 cycles; blink_en=0 → stored value is constant.
- Reset mid-SHIFT (cycle 10 of 20) → no done pulse, hex BLANK; a new transfer afterwards converts correctly.
